// File: rtl/fib_sched_pkg.sv
// Shared types and widths for the Fibonacci job scheduler.
package fib_sched_pkg;

  localparam int unsigned FIB_N_W   = 6;
  localparam int unsigned FIB_RES_W = 32;
  localparam int unsigned FIB_MAX_N = 47;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StStart,
    StWait,
    StResp
  } sched_state_e;

endpackage

// File: rtl/fib_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module fib_rr_arbiter
  import fib_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         win,
  output logic [$clog2(N_REQ)-1:0] win_idx
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  int unsigned idx;
  logic        found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/fib_job_scheduler.sv
// Shares one Fibonacci engine between N_REQ requesters with round-robin arbitration.
// Optional engine watchdog: define FIB_TIMEOUT_EN.
module fib_job_scheduler
  import fib_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_N       = FIB_MAX_N,
  parameter int unsigned TIMEOUT_CYC = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [FIB_N_W*N_REQ-1:0]     req_n,
  output logic [N_REQ-1:0]             gnt,
  output logic                         rsp_valid,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [FIB_RES_W-1:0]         rsp_res,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         eng_clr,
  output logic                         eng_start,
  output logic [FIB_N_W-1:0]           eng_n,
  input  logic                         eng_done,
  input  logic [FIB_RES_W-1:0]         eng_res
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam logic [FIB_N_W-1:0] MaxN = FIB_N_W'(MAX_N);

  if (N_REQ < 2 || N_REQ > 8 || MAX_N > 63 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("fib_job_scheduler: unsupported parameter combination");
  end

  sched_state_e         state_q;
  logic [IdxW-1:0]      ptr_q;
  logic [IdxW-1:0]      id_q;
  logic [FIB_N_W-1:0]   n_q;
  logic [N_REQ-1:0]     gnt_q;
  logic                 rsp_valid_q;
  logic [FIB_RES_W-1:0] rsp_res_q;
  logic                 rsp_err_q;
  logic                 eng_start_q;

  logic [N_REQ-1:0]     win;
  logic [IdxW-1:0]      win_idx;
  logic [FIB_N_W-1:0]   sel_n;

`ifdef FIB_TIMEOUT_EN
  localparam int unsigned ToW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [ToW-1:0] to_cnt_q;
  logic           to_q;
`endif

  fib_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb sel_n = req_n[FIB_N_W*win_idx +: FIB_N_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      n_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      eng_start_q <= 1'b0;
`ifdef FIB_TIMEOUT_EN
      to_cnt_q    <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      eng_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (|req) begin
            id_q  <= win_idx;
            n_q   <= sel_n;
            ptr_q <= (win_idx == IdxW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            gnt_q <= win;
            // Out-of-range n never touches the engine; answer in the grant cycle.
            if (sel_n > MaxN) begin
              rsp_valid_q <= 1'b1;
              rsp_res_q   <= '0;
              rsp_err_q   <= 1'b1;
              state_q     <= StResp;
            end else begin
              state_q <= StClr;
            end
          end
        end
        StClr: begin
          eng_start_q <= 1'b1;
          state_q     <= StStart;
        end
        StStart: begin
`ifdef FIB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= StWait;
        end
        StWait: begin
          if (eng_done) begin
            rsp_res_q   <= eng_res;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
`ifdef FIB_TIMEOUT_EN
          end else if (to_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            to_q        <= 1'b1;
            state_q     <= StResp;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
`endif
          end
        end
        StResp: begin
`ifdef FIB_TIMEOUT_EN
          to_q <= 1'b0;
`endif
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);
  assign eng_start = eng_start_q;
  assign eng_n     = n_q;

  // Clear during reset too, and after a watchdog expiry so a hung engine restarts clean.
`ifdef FIB_TIMEOUT_EN
  assign eng_clr = reset | (state_q == StClr) | ((state_q == StResp) & to_q);
`else
  assign eng_clr = reset | (state_q == StClr);
`endif

endmodule

// File: tb/tb_fib_job_scheduler.sv
// Scoreboard bench for fib_job_scheduler with a behavioural Fibonacci engine.
module tb_fib_job_scheduler;
  import fib_sched_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req;
  logic [6*N-1:0]   req_n = '0;
  logic [N-1:0]     gnt;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [31:0]      rsp_res;
  logic             rsp_err;
  logic             busy;
  logic             eng_clr;
  logic             eng_start;
  logic [5:0]       eng_n;
  logic             eng_done;
  logic [31:0]      eng_res;

  fib_job_scheduler #(
    .N_REQ       (N),
    .MAX_N       (47),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_n     (req_n),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_clr   (eng_clr),
    .eng_start (eng_start),
    .eng_n     (eng_n),
    .eng_done  (eng_done),
    .eng_res   (eng_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Engine model: iterative Fibonacci, done after a short n-dependent delay.
  function automatic logic [31:0] fib(input logic [5:0] n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  bit eng_mute = 1'b0;
  bit eng_run;
  int eng_cnt;
  always @(posedge clk) begin
    if (eng_clr) begin
      eng_done <= 1'b0;
      eng_run  <= 1'b0;
      eng_res  <= '0;
    end else if (eng_start) begin
      eng_run <= 1'b1;
      eng_cnt <= 4 + int'(eng_n % 4);
      eng_res <= fib(eng_n);
    end else if (eng_run && !eng_mute) begin
      if (eng_cnt == 0) begin
        eng_done <= 1'b1;
        eng_run  <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  // Requesters: a line is high while raises outnumber grants.
  int req_cnt[N];
  int gnt_cnt[N];
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = (req_cnt[i] != gnt_cnt[i]);
  end

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    int          kind;  // 0 engine result, 1 range reject, 2 watchdog
  } rsp_t;

  rsp_t exp_rsp[$];
  int   exp_gnt[$];
  int   exp_n[$];

  int last_gnt_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit done_seen = 1'b0;
  int n_starts = 0;
  int n_rsps = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != '0) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", gnt, 0);
        else chk("gnt", gnt, 64'(1) << exp_gnt.pop_front());
        for (int i = 0; i < N; i++) if (gnt[i]) gnt_cnt[i]++;
        last_gnt_cyc = cyc;
      end
      if (eng_start) begin
        n_starts++;
        start_cyc = cyc;
        done_seen = 1'b0;
        chk("start_lat", cyc, last_gnt_cyc + 1);
        if (exp_n.size() == 0) chk("start_unexpected", 1, 0);
        else chk("eng_n", eng_n, exp_n.pop_front());
      end
      if (eng_done === 1'b1 && !done_seen && busy) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (rsp_valid) begin
        rsp_t e;
        n_rsps++;
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_err", rsp_err, e.err);
          case (e.kind)
            0: chk("rsp_lat", cyc, done_cyc + 1);
            1: chk("reject_lat", cyc, last_gnt_cyc);
            default: begin
              chk("timeout_lat", cyc, start_cyc + 1 + TMO);
              chk("timeout_clr", eng_clr, 1);
            end
          endcase
        end
      end
    end
  end

  task automatic raise(input int id, input int n);
    req_n[6*id +: 6] = 6'(n);
    req_cnt[id]++;
  endtask

  task automatic expect_job(input int id, input int n, input logic [31:0] res);
    rsp_t e;
    exp_gnt.push_back(id);
    e.id = id;
    e.res = (n > 47) ? 32'd0 : res;
    e.err = (n > 47);
    e.kind = (n > 47) ? 1 : 0;
    if (n <= 47) exp_n.push_back(n);
    exp_rsp.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_rsp.size() != 0 || busy || req != '0) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= budget) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int c0;
    int k;
    for (int i = 0; i < N; i++) begin
      req_cnt[i] = 0;
      gnt_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_eng_clr", eng_clr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_eng_start", eng_start, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Contention from ptr 0: served 0,1,2,3.
    for (int i = 0; i < 4; i++) expect_job(i, 5 + i, (i == 0) ? 5 : (i == 1) ? 8 : (i == 2) ? 13 : 21);
    for (int i = 0; i < 4; i++) raise(i, 5 + i);
    drain(400);

    // Pointer wrapped back to 0: 0 beats 1.
    expect_job(0, 2, 1);
    expect_job(1, 3, 2);
    raise(1, 3);
    raise(0, 2);
    drain(200);

    // Single job, latency from request.
    s0 = n_starts;
    expect_job(0, 10, 55);
    c0 = cyc;
    raise(0, 10);
    drain(200);
    chk("gnt_lat", last_gnt_cyc, c0 + 1);
    chk("single_starts", n_starts, s0 + 1);

    // ptr now 1: req 3 served before req 0.
    expect_job(3, 3, 2);
    expect_job(0, 4, 3);
    raise(0, 4);
    raise(3, 3);
    drain(200);

    // Range rejects never start the engine.
    s0 = n_starts;
    expect_job(2, 48, 0);
    raise(2, 48);
    drain(50);
    expect_job(1, 63, 0);
    raise(1, 63);
    drain(50);
    chk("reject_no_start", n_starts, s0);

    // Boundaries.
    expect_job(3, 47, 32'd2971215073);
    raise(3, 47);
    drain(200);
    expect_job(1, 0, 0);
    raise(1, 0);
    drain(200);
    expect_job(2, 1, 1);
    raise(2, 1);
    drain(200);

    // Reset while waiting on the engine: job dropped.
    s0 = n_starts;
    exp_gnt.push_back(1);
    exp_n.push_back(20);
    raise(1, 20);
    k = 0;
    while (n_starts == s0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 50) chk("start_wait_timeout", 0, 1);
    @(posedge clk);
    #1;
    c0 = n_rsps;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midjob_rst_eng_clr", eng_clr, 1);
    chk("midjob_rst_busy", busy, 0);
    chk("midjob_rst_rsp_valid", rsp_valid, 0);
    chk("midjob_rst_rsp_res", rsp_res, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_rsp_after_reset", n_rsps, c0);
    chk("busy_after_reset", busy, 0);

    // Pointer re-initialised: 0 before 3.
    expect_job(0, 3, 2);
    expect_job(3, 2, 1);
    raise(3, 2);
    raise(0, 3);
    drain(200);

`ifdef FIB_TIMEOUT_EN
    begin
      rsp_t e;
      eng_mute = 1'b1;
      exp_gnt.push_back(2);
      exp_n.push_back(9);
      e.id = 2;
      e.res = 0;
      e.err = 1'b1;
      e.kind = 2;
      exp_rsp.push_back(e);
      raise(2, 9);
      drain(400);
      eng_mute = 1'b0;
      expect_job(3, 6, 8);
      raise(3, 6);
      drain(200);
    end
`endif

    chk("queues_empty", exp_gnt.size() + exp_n.size() + exp_rsp.size(), 0);
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "bench stalled");
  end

endmodule
